// File: rtl/iir_biquad_cascade_if.sv
// Sample stream, coefficient load and status signals of the biquad cascade.
// The master side feeds samples and coefficients; the slave side is the filter.
interface iir_biquad_cascade_if #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned COEF_W  = 16,
   parameter int unsigned NUM_SEC = 2
);
   localparam int unsigned ADDR_W = $clog2(5 * NUM_SEC);

   logic              In_VALID;
   logic              In_READY;
   logic [DATA_W-1:0] Data_IN;
   logic              Bypass;
   logic              Clr_STATE;
   logic              Coef_WE;
   logic [ADDR_W-1:0] Coef_ADDR;
   logic [COEF_W-1:0] Coef_DATA;
   logic              Out_VALID;
   logic [DATA_W-1:0] Data_OUT;
   logic              Sat_FLAG;

   modport master (
      output In_VALID, Data_IN, Bypass, Clr_STATE, Coef_WE, Coef_ADDR, Coef_DATA,
      input  In_READY, Out_VALID, Data_OUT, Sat_FLAG
   );

   modport slave (
      input  In_VALID, Data_IN, Bypass, Clr_STATE, Coef_WE, Coef_ADDR, Coef_DATA,
      output In_READY, Out_VALID, Data_OUT, Sat_FLAG
   );
endinterface

// File: rtl/iir_biquad_cascade.sv
// Cascade of NUM_SEC Direct-Form-I biquads sharing one MAC: five taps per section,
// then one cycle to round, saturate and shift the delay lines.
module iir_biquad_cascade #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned COEF_W  = 16,
   parameter int unsigned FRAC    = 14,
   parameter int unsigned NUM_SEC = 2,
   parameter int unsigned ACC_W   = 40
) (
   input logic                CLK,
   input logic                RESET_N,
   iir_biquad_cascade_if.slave bus
);
   localparam int unsigned NCOEF  = 5 * NUM_SEC;
   localparam int unsigned ADDR_W = $clog2(NCOEF);
   localparam int unsigned SEC_W  = (NUM_SEC > 1) ? $clog2(NUM_SEC) : 1;
   localparam int unsigned PROD_W = COEF_W + DATA_W;

   localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(64'sd1 <<< FRAC);
   localparam logic signed [ACC_W-1:0]  RND_HALF = ACC_W'(64'sd1 <<< (FRAC - 1));
   localparam logic signed [ACC_W-1:0]  Y_MAX    = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0]  Y_MIN    = ~Y_MAX;

   typedef enum logic [1:0] {StIdle, StMac, StSecEnd} state_t;

   state_t state_q, state_d;

   logic signed [COEF_W-1:0] coef_q [NCOEF];
   logic signed [DATA_W-1:0] x1_q [NUM_SEC];
   logic signed [DATA_W-1:0] x2_q [NUM_SEC];
   logic signed [DATA_W-1:0] y1_q [NUM_SEC];
   logic signed [DATA_W-1:0] y2_q [NUM_SEC];

   logic signed [DATA_W-1:0] x_q;
   logic        [DATA_W-1:0] in_q;
   logic                     byp_q;
   logic signed [ACC_W-1:0]  acc_q;
   logic        [SEC_W-1:0]  sec_q;
   logic        [2:0]        tap_q;
   logic        [DATA_W-1:0] data_out_q;
   logic                     out_valid_q;
   logic                     sat_q;

   logic                     accept;
   logic                     last_sec;
   logic        [ADDR_W-1:0] coef_idx;
   logic signed [COEF_W-1:0] coef_sel;
   logic signed [DATA_W-1:0] op_sel;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  acc_next;
   logic signed [ACC_W-1:0]  rnd;
   logic                     sat_hi;
   logic                     sat_lo;
   logic signed [DATA_W-1:0] y_sec;

   assign accept   = (state_q == StIdle) && bus.In_VALID;
   assign last_sec = (32'(sec_q) == NUM_SEC - 1);

   assign bus.In_READY  = (state_q == StIdle);
   assign bus.Out_VALID = out_valid_q;
   assign bus.Data_OUT  = data_out_q;
   assign bus.Sat_FLAG  = sat_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (accept) state_d = StMac;
         StMac:    if (tap_q == 3'd4) state_d = StSecEnd;
         StSecEnd: state_d = last_sec ? StIdle : StMac;
         default:  state_d = StIdle;
      endcase
   end

   // Taps 3 and 4 hold the feedback terms, which are subtracted rather than negated
   // so that a state of -2^(DATA_W-1) needs no extra bit.
   always_comb begin
      coef_idx = ADDR_W'(32'(sec_q) * 32'd5 + 32'(tap_q));
      coef_sel = coef_q[coef_idx];
      unique case (tap_q)
         3'd0:    op_sel = x_q;
         3'd1:    op_sel = x1_q[sec_q];
         3'd2:    op_sel = x2_q[sec_q];
         3'd3:    op_sel = y1_q[sec_q];
         default: op_sel = y2_q[sec_q];
      endcase
      prod     = PROD_W'(coef_sel) * PROD_W'(op_sel);
      prod_ext = ACC_W'(prod);
      acc_next = (tap_q < 3'd3) ? (acc_q + prod_ext) : (acc_q - prod_ext);
   end

   always_comb begin
      rnd    = (acc_q + RND_HALF) >>> FRAC;
      sat_hi = (rnd > Y_MAX);
      sat_lo = (rnd < Y_MIN);
      if (sat_hi) begin
         y_sec = Y_MAX[DATA_W-1:0];
      end else if (sat_lo) begin
         y_sec = Y_MIN[DATA_W-1:0];
      end else begin
         y_sec = rnd[DATA_W-1:0];
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < int'(NCOEF); i++) begin
            coef_q[i] <= ((i % 5) == 0) ? COEF_ONE : '0;
         end
         for (int s = 0; s < int'(NUM_SEC); s++) begin
            x1_q[s] <= '0;
            x2_q[s] <= '0;
            y1_q[s] <= '0;
            y2_q[s] <= '0;
         end
         x_q         <= '0;
         in_q        <= '0;
         byp_q       <= 1'b0;
         acc_q       <= '0;
         sec_q       <= '0;
         tap_q       <= '0;
         data_out_q  <= '0;
         out_valid_q <= 1'b0;
         sat_q       <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               // Clear lands before the accepted sample reaches the MAC.
               if (bus.Clr_STATE) begin
                  for (int s = 0; s < int'(NUM_SEC); s++) begin
                     x1_q[s] <= '0;
                     x2_q[s] <= '0;
                     y1_q[s] <= '0;
                     y2_q[s] <= '0;
                  end
                  sat_q <= 1'b0;
               end
               if (bus.Coef_WE && (32'(bus.Coef_ADDR) < NCOEF)) begin
                  coef_q[bus.Coef_ADDR] <= bus.Coef_DATA;
               end
               if (accept) begin
                  in_q  <= bus.Data_IN;
                  x_q   <= bus.Data_IN;
                  byp_q <= bus.Bypass;
                  acc_q <= '0;
                  sec_q <= '0;
                  tap_q <= '0;
               end
            end
            StMac: begin
               acc_q <= acc_next;
               tap_q <= tap_q + 3'd1;
            end
            StSecEnd: begin
               if (!byp_q) begin
                  x2_q[sec_q] <= x1_q[sec_q];
                  x1_q[sec_q] <= x_q;
                  y2_q[sec_q] <= y1_q[sec_q];
                  y1_q[sec_q] <= y_sec;
                  if (sat_hi || sat_lo) sat_q <= 1'b1;
               end
               if (!last_sec) begin
                  x_q   <= y_sec;
                  sec_q <= sec_q + SEC_W'(1);
                  acc_q <= '0;
                  tap_q <= '0;
               end else begin
                  data_out_q  <= byp_q ? in_q : y_sec;
                  out_valid_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Directed bench for the two-section biquad cascade with hand-computed expectations.
module tb_iir_biquad_cascade;
   logic CLK = 1'b0;
   logic RESET_N;
   int   checks = 0;
   int   failures = 0;

   iir_biquad_cascade_if #(.DATA_W(16), .COEF_W(16), .NUM_SEC(2)) bus ();

   iir_biquad_cascade #(
      .DATA_W(16), .COEF_W(16), .FRAC(14), .NUM_SEC(2), .ACC_W(40)
   ) dut (
      .CLK    (CLK),
      .RESET_N(RESET_N),
      .bus    (bus)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wcoef(input logic [3:0] addr, input logic [15:0] data);
      bus.Coef_WE   = 1'b1;
      bus.Coef_ADDR = addr;
      bus.Coef_DATA = data;
      tick();
      bus.Coef_WE   = 1'b0;
   endtask

   task automatic clr();
      bus.Clr_STATE = 1'b1;
      tick();
      bus.Clr_STATE = 1'b0;
   endtask

   task automatic send(input logic [15:0] din, input logic byp,
                       output logic [15:0] dout, output int lat);
      int n;
      n = 0;
      while (!bus.In_READY && n < 50) begin
         tick();
         n++;
      end
      bus.In_VALID = 1'b1;
      bus.Data_IN  = din;
      bus.Bypass   = byp;
      tick();
      bus.In_VALID = 1'b0;
      bus.Bypass   = 1'b0;
      lat = 0;
      while (!bus.Out_VALID && lat < 50) begin
         tick();
         lat++;
      end
      dout = bus.Data_OUT;
   endtask

   initial begin
      logic [15:0] y;
      int          lat;
      int          acc_t [4];
      int          na;
      logic        rdy;
      logic        rdy_busy;
      int          pulses;
      logic [15:0] rec_exp [4];

      bus.In_VALID  = 1'b0;
      bus.Data_IN   = '0;
      bus.Bypass    = 1'b0;
      bus.Clr_STATE = 1'b0;
      bus.Coef_WE   = 1'b0;
      bus.Coef_ADDR = '0;
      bus.Coef_DATA = '0;
      RESET_N       = 1'b0;
      #12;
      check("reset_in_ready", 32'(bus.In_READY), 32'd1);
      check("reset_out_valid", 32'(bus.Out_VALID), 32'd0);
      check("reset_data_out", 32'(bus.Data_OUT), 32'h0);
      check("reset_sat_flag", 32'(bus.Sat_FLAG), 32'd0);
      tick();
      RESET_N = 1'b1;
      tick();

      // Passthrough with reset coefficients
      send(16'h1000, 1'b0, y, lat);
      check("pass_latency", 32'(lat), 32'd12);
      check("pass_data", 32'(y), 32'h1000);

      // Gain 0.5 in section 0
      wcoef(4'd0, 16'h2000);
      send(16'h4000, 1'b0, y, lat);
      check("gain_data", 32'(y), 32'h2000);
      check("gain_sat", 32'(bus.Sat_FLAG), 32'd0);

      // First-order recursion y = x + 0.5*y1
      wcoef(4'd0, 16'h4000);
      wcoef(4'd3, 16'hE000);
      clr();
      rec_exp[0] = 16'h1000;
      rec_exp[1] = 16'h0800;
      rec_exp[2] = 16'h0400;
      rec_exp[3] = 16'h0200;
      for (int k = 0; k < 4; k++) begin
         send((k == 0) ? 16'h1000 : 16'h0000, 1'b0, y, lat);
         check($sformatf("recur_%0d", k), 32'(y), 32'(rec_exp[k]));
      end

      // Saturation at both rails, sticky flag, clear
      wcoef(4'd3, 16'h0000);
      wcoef(4'd0, 16'h7FFF);
      clr();
      send(16'h7000, 1'b0, y, lat);
      check("sat_pos_data", 32'(y), 32'h7FFF);
      check("sat_pos_flag", 32'(bus.Sat_FLAG), 32'd1);
      send(16'h9000, 1'b0, y, lat);
      check("sat_neg_data", 32'(y), 32'h8000);
      wcoef(4'd0, 16'h4000);
      send(16'h0100, 1'b0, y, lat);
      check("sat_sticky", 32'(bus.Sat_FLAG), 32'd1);
      clr();
      check("sat_clr", 32'(bus.Sat_FLAG), 32'd0);

      // Back-to-back accepts with In_VALID held; a busy coefficient write is dropped
      wcoef(4'd0, 16'h2000);
      clr();
      for (int k = 0; k < 4; k++) acc_t[k] = -100;
      na       = 0;
      rdy_busy = 1'b1;
      bus.In_VALID = 1'b1;
      bus.Data_IN  = 16'h0100;
      for (int i = 0; i < 40; i++) begin
         rdy = bus.In_READY;
         if (i == 4) begin
            rdy_busy      = rdy;
            bus.Coef_WE   = 1'b1;
            bus.Coef_ADDR = 4'd0;
            bus.Coef_DATA = 16'h1000;
         end else begin
            bus.Coef_WE = 1'b0;
         end
         tick();
         if (rdy) begin
            if (na < 4) acc_t[na] = i;
            na++;
         end
      end
      bus.In_VALID = 1'b0;
      bus.Coef_WE  = 1'b0;
      check("hs_accept_count", 32'(na), 32'd4);
      check("hs_gap_0", 32'(acc_t[1] - acc_t[0]), 32'd13);
      check("hs_gap_1", 32'(acc_t[2] - acc_t[1]), 32'd13);
      check("hs_ready_busy", 32'(rdy_busy), 32'd0);
      send(16'h4000, 1'b0, y, lat);
      check("hs_gain_kept", 32'(y), 32'h2000);

      // Bypass leaves the history of the recursive section untouched
      wcoef(4'd0, 16'h4000);
      wcoef(4'd3, 16'hE000);
      clr();
      send(16'h1000, 1'b0, y, lat);
      check("byp_pre", 32'(y), 32'h1000);
      send(16'h1234, 1'b1, y, lat);
      check("byp_data", 32'(y), 32'h1234);
      check("byp_latency", 32'(lat), 32'd12);
      send(16'h0000, 1'b0, y, lat);
      check("byp_history", 32'(y), 32'h0800);

      // Reset during MAC aborts the sample and restores passthrough coefficients
      wcoef(4'd3, 16'h0000);
      wcoef(4'd0, 16'h2000);
      bus.In_VALID = 1'b1;
      bus.Data_IN  = 16'h4000;
      tick();
      bus.In_VALID = 1'b0;
      tick();
      tick();
      tick();
      RESET_N = 1'b0;
      #1;
      check("midrst_out_valid", 32'(bus.Out_VALID), 32'd0);
      check("midrst_in_ready", 32'(bus.In_READY), 32'd1);
      check("midrst_data_out", 32'(bus.Data_OUT), 32'h0);
      tick();
      tick();
      tick();
      RESET_N = 1'b1;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.Out_VALID) pulses++;
      end
      check("midrst_no_pulse", 32'(pulses), 32'd0);
      send(16'h0555, 1'b0, y, lat);
      check("midrst_pass", 32'(y), 32'h0555);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
